// File: rtl/alu_mdu.sv
// Execute-stage ALU (single-cycle, combinational) plus a multi-cycle
// multiply/divide unit that commits into HI/LO after a fixed latency.
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  input  logic [2:0]       MDOp,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SH_W    = $clog2(WIDTH);
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [2:0]               op_p0;
  logic [WIDTH-1:0]         a_p0;
  logic [WIDTH-1:0]         b_p0;
  logic [2*WIDTH-1:0]       md_res;
  logic                     accept_md;
  logic signed [WIDTH-1:0]  a_s;
  logic [SH_W-1:0]          shamt;

  // Full 2*WIDTH product; sign-extending both operands makes the low
  // 2*WIDTH bits of the product exact for the signed case.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic signed [2*WIDTH-1:0] pa;
    logic signed [2*WIDTH-1:0] pb;
    logic signed [2*WIDTH-1:0] prod;
    pa   = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    pb   = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod = pa * pb;
    return prod;
  endfunction

  // Returns {remainder, quotient}. Divide-by-zero and the single signed
  // overflow case are resolved explicitly so no X/trap ever reaches HI/LO.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)) begin
      q = a;
      r = '0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign a_s   = A;
  assign shamt = B[SH_W-1:0];

  // Combinational ALU; unused opcodes produce zero.
  always_comb begin
    C = '0;
    case (ALUOp)
      3'd0:    C = A + B;
      3'd1:    C = A - B;
      3'd2:    C = A & B;
      3'd3:    C = A | B;
      3'd4:    C = A >> shamt;
      3'd5:    C = a_s >>> shamt;
      default: C = '0;
    endcase
  end

  // A multiply/divide is accepted only when the unit is not running.
  assign accept_md = start && (state != RUN) &&
                     ((MDOp == MD_MULT) || (MDOp == MD_MULTU) ||
                      (MDOp == MD_DIV)  || (MDOp == MD_DIVU));

  // Operand capture at start; later A/B changes do not affect the op.
  always_ff @(posedge clk) begin
    if (accept_md) begin
      a_p0 <= A;
      b_p0 <= B;
    end
  end

  // Result selected from the latched operation and operands.
  always_comb begin
    md_res = '0;
    case (op_p0)
      MD_MULT:  md_res = mul_full(a_p0, b_p0, 1'b1);
      MD_MULTU: md_res = mul_full(a_p0, b_p0, 1'b0);
      MD_DIV:   md_res = div_full(a_p0, b_p0, 1'b1);
      MD_DIVU:  md_res = div_full(a_p0, b_p0, 1'b0);
      default:  md_res = '0;
    endcase
  end

  // MDU control FSM with registered busy/done and HI/LO writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_p0 <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cnt == '0) begin
            HI    <= md_res[2*WIDTH-1:WIDTH];
            LO    <= md_res[WIDTH-1:0];
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            case (MDOp)
              MD_MULT, MD_MULTU: begin
                op_p0 <= MDOp;
                cnt   <= CNT_W'(MUL_CYCLES - 1);
                state <= RUN;
                busy  <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                op_p0 <= MDOp;
                cnt   <= CNT_W'(DIV_CYCLES - 1);
                state <= RUN;
                busy  <= 1'b1;
              end
              MD_MTHI: HI <= A;
              MD_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH=32, MUL=5, DIV=10).
module tb_alu_mdu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;
  logic [31:0] C;
  logic [2:0]  MDOp;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .ALUOp (ALUOp),
    .C     (C),
    .MDOp  (MDOp),
    .start (start),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    ALUOp = op;
    A     = a;
    B     = b;
    #1;
    chk(tag, C, exp);
  endtask

  // Issue one MDU op, scramble operands during RUN, count busy cycles,
  // then check results, the done pulse and its one-cycle width.
  task automatic md_op(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input int n,
                       input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    @(negedge clk);
    A = a; B = b; MDOp = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd0; A = 32'h5555_AAAA; B = 32'h0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk({tag, " busy_cycles"}, cyc, n);
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " HI"}, HI, ehi);
    chk({tag, " LO"}, LO, elo);
    @(posedge clk); #1;
    chk({tag, " done_drop"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; A = '0; B = '0; ALUOp = '0; MDOp = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst HI", HI, 32'd0);
    chk("rst LO", LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    alu_vec("alu sra", 3'd5, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    alu_vec("alu srl", 3'd4, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    alu_vec("alu op7", 3'd7, 32'h8000_0000, 32'h0000_0024, 32'h0000_0000);
    alu_vec("alu op6", 3'd6, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000);
    alu_vec("alu add wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    alu_vec("alu sub wrap", 3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    alu_vec("alu and", 3'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu_vec("alu or", 3'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    alu_vec("alu sra pos", 3'd5, 32'h4000_0000, 32'h0000_0003, 32'h0800_0000);

    md_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    md_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    md_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_op("div negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    md_op("divu by0", 3'd4, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF);
    md_op("div by0", 3'd3, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    md_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    md_op("divu",  3'd4, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);

    // mthi / mtlo write at the accepting edge with no busy/done
    @(negedge clk);
    A = 32'h0000_1234; MDOp = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd0;
    chk("mthi HI", HI, 32'h0000_1234);
    chk("mthi busy", {31'b0, busy}, 32'd0);
    chk("mthi done", {31'b0, done}, 32'd0);
    @(negedge clk);
    A = 32'h0000_5678; MDOp = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd0;
    chk("mtlo LO", LO, 32'h0000_5678);
    chk("mtlo HI kept", HI, 32'h0000_1234);

    // start while running is ignored
    @(negedge clk);
    A = 32'hFFFF_FFFE; B = 32'd3; MDOp = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    A = 32'h0000_DEAD; MDOp = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    A = 32'h0000_0100; B = 32'd7; MDOp = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd0;
    cyc = 4;
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("ignore busy_cycles", cyc, 32'd5);
    chk("ignore HI", HI, 32'hFFFF_FFFF);
    chk("ignore LO", LO, 32'hFFFF_FFFA);
    chk("ignore done", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    chk("ignore no restart", {31'b0, busy}, 32'd0);

    // async reset mid-run clears everything immediately
    @(negedge clk);
    A = 32'd100; B = 32'd3; MDOp = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre-rst busy", {31'b0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst HI", HI, 32'd0);
    chk("midrst LO", LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    md_op("multu max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
